bpsk_frame_modulator: RTL and testbench



---
 rtl/bpsk_mod_pkg.sv | 33 +++
 rtl/bpsk_bit_skid.sv | 42 ++++
 rtl/bpsk_frame_modulator.sv | 172 +++++++++++++++++
 tb/tb_bpsk_frame_modulator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_mod_pkg.sv
// Shared types and helpers for the BPSK frame modulator: FSM states, symbol
// timing, preamble pattern and saturating negation.
package bpsk_mod_pkg;

  localparam int unsigned DEF_SAMPLE_WIDTH = 16;
  localparam int unsigned DEF_CARRIER_SPP  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_STALL
  } state_t;

  function automatic int unsigned calc_sps(input int unsigned cspp, input int unsigned pps);
    return cspp * pps;
  endfunction

  function automatic logic preamble_sym(input int unsigned idx);
    return ((idx % 2) == 0);
  endfunction

  // Two's-complement negate of a w-bit value held sign-extended in 64 bits;
  // the most-negative input maps to the most-positive value instead of itself.
  function automatic logic signed [63:0] sat_neg(input logic signed [63:0] v,
                                                 input int unsigned w);
    logic signed [63:0] v_min;
    v_min = -(64'sd1 <<< (w - 1));
    if (v == v_min) return -v - 64'sd1;
    return -v;
  endfunction

endpackage

// File: rtl/bpsk_bit_skid.sv
// One-entry data-bit buffer with valid/ready on the input side and a
// consume strobe from the modulator; stores the bit with its last flag.
module bpsk_bit_skid (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i_valid,
  input  logic i_bit,
  input  logic i_last,
  input  logic i_consume,
  output logic o_ready,
  output logic o_full,
  output logic o_bit,
  output logic o_last
);

  logic r_full;
  logic r_bit;
  logic r_last;
  logic w_accept;

  assign o_ready  = rst_n && !r_full;
  assign w_accept = en && i_valid && o_ready;
  assign o_full   = r_full;
  assign o_bit    = r_bit;
  assign o_last   = r_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_bit  <= 1'b0;
      r_last <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        r_bit  <= i_bit;
        r_last <= i_last;
      end
      r_full <= w_accept || (r_full && !i_consume);
    end
  end

endmodule

// File: rtl/bpsk_frame_modulator.sv
// Frame-oriented BPSK modulator: alternating preamble, then buffered data
// bits (optionally differentially encoded) mapped onto a cosine LUT carrier.
module bpsk_frame_modulator import bpsk_mod_pkg::*; #(
  parameter int unsigned SAMPLE_WIDTH               = DEF_SAMPLE_WIDTH,
  parameter int unsigned CARRIER_SAMPLES_PER_PERIOD = DEF_CARRIER_SPP,
  parameter int unsigned PERIODS_PER_SYMBOL         = 4,
  parameter int unsigned PREAMBLE_LEN               = 16,
  parameter int unsigned DIFF_EN                    = 0
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic                                          frame_start,
  input  logic                                          bit_in,
  input  logic                                          bit_valid,
  input  logic                                          bit_last,
  output logic                                          bit_ready,
  output logic [$clog2(CARRIER_SAMPLES_PER_PERIOD)-1:0] cosine_lu,
  input  logic [SAMPLE_WIDTH-1:0]                       carrier,
  output logic [SAMPLE_WIDTH-1:0]                       out,
  output logic                                          out_valid,
  output logic                                          busy,
  output logic                                          underrun
);

  localparam int unsigned SPS  = calc_sps(CARRIER_SAMPLES_PER_PERIOD, PERIODS_PER_SYMBOL);
  localparam int unsigned CW   = $clog2(SPS);
  localparam int unsigned PW   = $clog2(CARRIER_SAMPLES_PER_PERIOD);
  localparam int unsigned SYMW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;

  state_t r_state, w_state_nxt;

  logic [CW-1:0]           r_sample_cnt;
  logic [SYMW-1:0]         r_sym_cnt;
  logic                    r_tx;
  logic                    r_last;
  logic                    r_preloaded;
  logic [SAMPLE_WIDTH-1:0] r_out;
  logic                    r_out_valid;
  logic                    r_underrun;

  logic                    w_buf_full;
  logic                    w_buf_bit;
  logic                    w_buf_last;
  logic                    w_consume;
  logic                    w_enc;
  logic                    w_tx;
  logic                    w_last;
  logic                    w_active;
  logic                    w_underrun;
  logic                    w_frame_go;
  logic                    w_sym_end;
  logic [SAMPLE_WIDTH-1:0] w_neg;

  bpsk_bit_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .i_valid   (bit_valid),
    .i_bit     (bit_in),
    .i_last    (bit_last),
    .i_consume (w_consume),
    .o_ready   (bit_ready),
    .o_full    (w_buf_full),
    .o_bit     (w_buf_bit),
    .o_last    (w_buf_last)
  );

  // phase equals the low bits of sample_cnt since SPS is a multiple of the LUT period
  assign cosine_lu = (r_state == ST_IDLE) ? '0 : r_sample_cnt[PW-1:0];
  assign w_sym_end = (r_sample_cnt == CW'(SPS - 1));
  assign w_enc     = (DIFF_EN != 0) ? (w_buf_bit ^ r_tx) : w_buf_bit;
  assign w_neg     = SAMPLE_WIDTH'(sat_neg(64'(signed'(carrier)), SAMPLE_WIDTH));

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != ST_IDLE);
  assign underrun  = r_underrun;

  always_comb begin
    w_state_nxt = r_state;
    w_tx        = r_tx;
    w_last      = r_last;
    w_active    = 1'b0;
    w_consume   = 1'b0;
    w_underrun  = 1'b0;
    w_frame_go  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_frame_go  = 1'b1;
          w_state_nxt = (PREAMBLE_LEN == 0) ? ST_DATA : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        w_active = 1'b1;
        w_tx     = preamble_sym(32'(r_sym_cnt));
        if (w_sym_end && (r_sym_cnt == SYMW'(PREAMBLE_LEN - 1)))
          w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if ((r_sample_cnt == '0) && !r_preloaded) begin
          if (w_buf_full) begin
            w_consume = 1'b1;
            w_tx      = w_enc;
            w_last    = w_buf_last;
            w_active  = 1'b1;
          end else begin
            w_underrun  = 1'b1;
            w_state_nxt = ST_STALL;
          end
        end else begin
          w_active = 1'b1;
        end
        if (w_active && w_sym_end && w_last)
          w_state_nxt = ST_IDLE;
      end
      ST_STALL: begin
        if (w_buf_full) begin
          w_consume   = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_sym_cnt    <= '0;
      r_tx         <= 1'b0;
      r_last       <= 1'b0;
      r_preloaded  <= 1'b0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (en) begin
      r_state    <= w_state_nxt;
      r_underrun <= w_underrun;
      if (w_frame_go) begin
        r_sample_cnt <= '0;
        r_sym_cnt    <= '0;
        r_tx         <= 1'b0;
        r_last       <= 1'b0;
        r_preloaded  <= 1'b0;
      end
      if (w_active) begin
        r_sample_cnt <= w_sym_end ? '0 : r_sample_cnt + 1'b1;
        r_tx         <= w_tx;
        r_last       <= w_last;
      end
      if ((r_state == ST_PREAMBLE) && w_sym_end)
        r_sym_cnt <= r_sym_cnt + 1'b1;
      // A symbol loaded while stalled is used at the next sample_cnt==0 without re-reading the buffer
      if ((r_state == ST_STALL) && w_consume) begin
        r_tx        <= w_enc;
        r_last      <= w_buf_last;
        r_preloaded <= 1'b1;
      end else if ((r_state == ST_DATA) && w_active) begin
        r_preloaded <= 1'b0;
      end
      r_out_valid <= w_active;
      if (r_state == ST_IDLE)
        r_out <= '0;
      else if (w_active)
        r_out <= w_tx ? carrier : w_neg;
    end
  end

endmodule

// File: tb/tb_bpsk_frame_modulator.sv
// Directed bench: two modulators (plain and differential) share stimulus and
// are compared each cycle against a step-indexed expected schedule.
module tb_bpsk_frame_modulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, frame_start, bit_in, bit_valid, bit_last;
  logic force_min;
  logic [2:0]  lu_a, lu_b;
  logic [15:0] car_a, car_b, out_a, out_b;
  logic ready_a, ready_b, ov_a, ov_b, busy_a, busy_b, und_a, und_b;

  int errors = 0;
  int checks = 0;
  int tid = 0;

  logic q_bit [4];
  logic q_lst [4];
  int   q_at  [4];
  int   q_len;

  logic [15:0] m_out_a, m_out_b;
  logic        m_ov;

  function automatic logic [15:0] lut(input logic [2:0] i);
    case (i)
      3'd0: return 16'h7FFF;
      3'd1: return 16'h5A82;
      3'd2: return 16'h0000;
      3'd3: return 16'hA57E;
      3'd4: return 16'h8001;
      3'd5: return 16'hA57E;
      3'd6: return 16'h0000;
      default: return 16'h5A82;
    endcase
  endfunction

  assign car_a = force_min ? 16'h8000 : lut(lu_a);
  assign car_b = force_min ? 16'h8000 : lut(lu_b);

  bpsk_frame_modulator #(.SAMPLE_WIDTH(16), .CARRIER_SAMPLES_PER_PERIOD(8),
    .PERIODS_PER_SYMBOL(1), .PREAMBLE_LEN(2), .DIFF_EN(0)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
    .bit_ready(ready_a), .cosine_lu(lu_a), .carrier(car_a), .out(out_a),
    .out_valid(ov_a), .busy(busy_a), .underrun(und_a));

  bpsk_frame_modulator #(.SAMPLE_WIDTH(16), .CARRIER_SAMPLES_PER_PERIOD(8),
    .PERIODS_PER_SYMBOL(1), .PREAMBLE_LEN(2), .DIFF_EN(1)) dut_d (
    .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_last(bit_last),
    .bit_ready(ready_b), .cosine_lu(lu_b), .carrier(car_b), .out(out_b),
    .out_valid(ov_b), .busy(busy_b), .underrun(und_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int s, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s step=%0d got=%0h exp=%0h", tag, s, got, exp);
    end
  endtask

  // tid 0: bits 1,0L; 1: underrun; 2: bits 1,1,0,0L; 3: forced carrier + en drop
  function automatic int f_len();
    case (tid)
      1: return 40;
      2: return 50;
      default: return 34;
    endcase
  endfunction

  function automatic logic f_busy(input int s);
    case (tid)
      1: return s < 37;
      2: return s < 48;
      default: return s < 32;
    endcase
  endfunction

  function automatic logic f_act(input int s);
    if (tid == 1) return (s < 24) || (s >= 29 && s < 37);
    return f_busy(s);
  endfunction

  function automatic logic [2:0] f_idx(input int s);
    if (!f_busy(s)) return 3'd0;
    if (tid == 1) begin
      if (s < 24) return 3'(s % 8);
      if (s < 29) return 3'd0;
      return 3'((s - 29) % 8);
    end
    return 3'(s % 8);
  endfunction

  function automatic logic f_tx(input int s);
    if (s < 8)  return 1'b1;
    if (s < 16) return 1'b0;
    case (tid)
      1: return s < 24;
      2: return s < 32;
      default: return s < 24;
    endcase
  endfunction

  function automatic logic f_txd(input int s);
    if (s < 8)  return 1'b1;
    if (s < 16) return 1'b0;
    if (tid == 2) return s < 24;
    return 1'b1;
  endfunction

  function automatic logic f_und(input int s);
    return (tid == 1) && (s == 25);
  endfunction

  function automatic logic [15:0] sample(input logic [2:0] idx, input logic tx);
    logic signed [15:0] v;
    v = force_min ? 16'sh8000 : signed'(lut(idx));
    if (tx) return v;
    if (v == 16'sh8000) return 16'h7FFF;
    return -v;
  endfunction

  task automatic run_frame();
    int s;
    int c;
    int q;
    logic hs;
    s = 0;
    c = 0;
    q = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_out_a = '0;
    m_out_b = '0;
    m_ov = 1'b0;
    while (s < f_len() && c < 200) begin
      en = !(tid == 3 && c >= 4 && c < 8);
      frame_start = (tid == 2 && s == 20);
      if (q < q_len && s >= q_at[q]) begin
        bit_valid = 1'b1;
        bit_in    = q_bit[q];
        bit_last  = q_lst[q];
      end else begin
        bit_valid = 1'b0;
      end
      chk("lu_a", s, 32'(lu_a), 32'(f_idx(s)));
      chk("lu_d", s, 32'(lu_b), 32'(f_idx(s)));
      chk("out_valid_a", s, 32'(ov_a), 32'(m_ov));
      chk("out_valid_d", s, 32'(ov_b), 32'(m_ov));
      chk("out_a", s, 32'(out_a), 32'(m_out_a));
      chk("out_d", s, 32'(out_b), 32'(m_out_b));
      chk("busy_a", s, 32'(busy_a), 32'(f_busy(s)));
      chk("busy_d", s, 32'(busy_b), 32'(f_busy(s)));
      chk("underrun_a", s, 32'(und_a), 32'(f_und(s)));
      chk("underrun_d", s, 32'(und_b), 32'(f_und(s)));
      hs = en && bit_valid && ready_a;
      tick();
      if (hs) q++;
      if (en) begin
        if (!f_busy(s)) begin
          m_ov = 1'b0;
          m_out_a = '0;
          m_out_b = '0;
        end else begin
          m_ov = f_act(s);
          if (f_act(s)) begin
            m_out_a = sample(f_idx(s), f_tx(s));
            m_out_b = sample(f_idx(s), f_txd(s));
          end
        end
        s++;
      end
      c++;
    end
    chk("frame_cycle_budget", s, 32'(c < 200), 32'd1);
    en = 1'b1;
    bit_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    frame_start = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    bit_last = 1'b0;
    force_min = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", i, 32'(out_a), 32'd0);
      chk("rst_out_valid", i, 32'(ov_a), 32'd0);
      chk("rst_busy", i, 32'(busy_a), 32'd0);
      chk("rst_bit_ready", i, 32'(ready_a), 32'd0);
      chk("rst_lu", i, 32'(lu_a), 32'd0);
    end
    rst_n = 1'b1;
    frame_start = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("rel_bit_ready", 0, 32'(ready_a), 32'd1);
    chk("rel_underrun", 0, 32'(und_a), 32'd0);
    tick();
    chk("idle_busy", 0, 32'(busy_a), 32'd0);

    tid = 0;
    q_len = 2;
    q_bit[0] = 1'b1; q_lst[0] = 1'b0; q_at[0] = 0;
    q_bit[1] = 1'b0; q_lst[1] = 1'b1; q_at[1] = 0;
    run_frame();

    tid = 1;
    q_len = 2;
    q_bit[0] = 1'b1; q_lst[0] = 1'b0; q_at[0] = 0;
    q_bit[1] = 1'b0; q_lst[1] = 1'b1; q_at[1] = 27;
    run_frame();

    tid = 2;
    q_len = 4;
    q_bit[0] = 1'b1; q_lst[0] = 1'b0; q_at[0] = 0;
    q_bit[1] = 1'b1; q_lst[1] = 1'b0; q_at[1] = 0;
    q_bit[2] = 1'b0; q_lst[2] = 1'b0; q_at[2] = 0;
    q_bit[3] = 1'b0; q_lst[3] = 1'b1; q_at[3] = 0;
    run_frame();

    tid = 3;
    force_min = 1'b1;
    q_len = 2;
    q_bit[0] = 1'b1; q_lst[0] = 1'b0; q_at[0] = 0;
    q_bit[1] = 1'b0; q_lst[1] = 1'b1; q_at[1] = 0;
    run_frame();
    force_min = 1'b0;

    chk("end_bit_ready", 0, 32'(ready_a), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
